// File: rtl/reg_file_8x_if.sv
// ---------------------------------------------------------------------------
// reg_file_8x_if
//   Port bundle for the eight-entry register file: one write port and two
//   read ports plus the accepted-write counter.
//
//   Signals
//     we       write enable, sampled on rising clk
//     waddr    write address (3 bits)
//     wdata    write data (DATA_W bits)
//     raddr_a  read port A address
//     rdata_a  read port A data, combinational
//     raddr_b  read port B address
//     rdata_b  read port B data, combinational
//     wr_cnt   count of accepted writes, wraps 255 -> 0
//
//   Modports
//     master   datapath side: drives addresses and write data
//     slave    register file side: drives read data and wr_cnt
// ---------------------------------------------------------------------------
interface reg_file_8x_if #(
  parameter int DATA_W = 32
);
  logic              we;
  logic [2:0]        waddr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic [2:0]        raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic [7:0]        wr_cnt;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_b, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_b, wr_cnt
  );
endinterface

// File: rtl/reg_file_8x.sv
// ---------------------------------------------------------------------------
// reg_file_8x
//   Eight-entry general register file for the MIPS datapath. One synchronous
//   write port, two asynchronous read ports feeding the ALU operand path.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; clears all entries and wr_cnt,
//            and forces both read ports to 0 while low
//     bus    reg_file_8x_if.slave (we/waddr/wdata, raddr_a/rdata_a,
//            raddr_b/rdata_b, wr_cnt)
//
//   Parameters
//     DATA_W    register width
//     ZERO_REG  1: entry 0 reads 0 and writes to it are dropped (not counted)
//
//   Build option
//     REGFILE_BYPASS_EN  when defined, a read of the address being written in
//                        the same cycle returns wdata (write-through). When
//                        undefined, the stored value is returned until the edge.
// ---------------------------------------------------------------------------
module reg_file_8x #(
  parameter int DATA_W   = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_8x_if.slave  bus
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] entry_r [8];
  logic [7:0]        wr_cnt_r;
  logic              wr_accept_s;
  logic [DATA_W-1:0] rdata_a_s;
  logic [DATA_W-1:0] rdata_b_s;

  // Read selection shared by both ports. Reset and the zero register take
  // priority over forwarding, so a bypassed write can never leak through them.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic              rst_ok,
    input logic [2:0]        raddr,
    input logic [DATA_W-1:0] stored,
    input logic              fwd_hit,
    input logic [DATA_W-1:0] fwd_data
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (!rst_ok) begin
      val = {DATA_W{1'b0}};
    end else if (ZERO_REG && (raddr == 3'd0)) begin
      val = {DATA_W{1'b0}};
    end else if (BYPASS && fwd_hit) begin
      val = fwd_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Write qualification: we gates everything, so X on waddr/wdata with we=0
  // cannot reach storage or the counter.
  always_comb begin
    wr_accept_s = 1'b0;
    if (bus.we == 1'b1) begin
      if (ZERO_REG && (bus.waddr == 3'd0)) begin
        wr_accept_s = 1'b0;
      end else begin
        wr_accept_s = 1'b1;
      end
    end else begin
      wr_accept_s = 1'b0;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        entry_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_accept_s) begin
      entry_r[bus.waddr] <= bus.wdata;
    end
  end

  // Accepted-write counter, wraps modulo 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r <= 8'd0;
    end else if (wr_accept_s) begin
      wr_cnt_r <= wr_cnt_r + 8'd1;
    end
  end

  // Read ports A and B, zero latency.
  always_comb begin
    rdata_a_s = read_sel(rst_n, bus.raddr_a, entry_r[bus.raddr_a],
                         wr_accept_s && (bus.raddr_a == bus.waddr), bus.wdata);
    rdata_b_s = read_sel(rst_n, bus.raddr_b, entry_r[bus.raddr_b],
                         wr_accept_s && (bus.raddr_b == bus.waddr), bus.wdata);
  end

  assign bus.rdata_a = rdata_a_s;
  assign bus.rdata_b = rdata_b_s;
  assign bus.wr_cnt  = wr_cnt_r;

endmodule

// File: tb/tb_reg_file_8x.sv
// ---------------------------------------------------------------------------
// tb_reg_file_8x
//   Directed bench for reg_file_8x. Stimulus drives one cycle at a time just
//   after the rising edge and queues the values the outputs must show before
//   the next rising edge; a monitor drains the queue on every falling edge.
// ---------------------------------------------------------------------------
module tb_reg_file_8x;

  localparam bit ZREG = 1'b1;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_A   = 0;
  localparam int K_B   = 1;
  localparam int K_CNT = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_it;
  logic [31:0] mon_act;
  int   exp_cnt;

  reg_file_8x_if #(.DATA_W(32)) bus ();

  reg_file_8x #(.DATA_W(32), .ZERO_REG(ZREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of stimulus shortly after the rising edge.
  task automatic drive(input logic w, input logic [2:0] wa, input logic [31:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb);
    @(posedge clk);
    #1;
    bus.we      = w;
    bus.waddr   = wa;
    bus.wdata   = wd;
    bus.raddr_a = ra;
    bus.raddr_b = rb;
  endtask

  task automatic expect_val(input int kind, input logic [31:0] val, input string name);
    exp_t it;
    it.kind = kind;
    it.exp  = val;
    it.name = name;
    exp_q.push_back(it);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_it = exp_q.pop_front();
      case (mon_it.kind)
        K_A:     mon_act = bus.rdata_a;
        K_B:     mon_act = bus.rdata_b;
        default: mon_act = {24'd0, bus.wr_cnt};
      endcase
      checks++;
      if (mon_act !== mon_it.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                 mon_it.name, mon_act, mon_it.exp, $time);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] fwd_v;
    logic [31:0] old_v;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.we = 1'b0; bus.waddr = 3'd0; bus.wdata = 32'd0;
    bus.raddr_a = 3'd0; bus.raddr_b = 3'd0;

    // Reset state; a write while in reset must be ignored.
    drive(1'b1, 3'd3, 32'h1234_5678, 3'd3, 3'd3);
    expect_val(K_A, 32'd0, "reset_rd_a");
    expect_val(K_B, 32'd0, "reset_rd_b");
    expect_val(K_CNT, 32'd0, "reset_cnt");
    drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd0);
    rst_n = 1'b1;
    expect_val(K_A, 32'd0, "write_in_reset_dropped");
    expect_val(K_CNT, 32'd0, "cnt_after_release");

    // Test 1: load entry 3 then clear asynchronously mid-cycle.
    drive(1'b1, 3'd3, 32'hDEAD_BEEF, 3'd0, 3'd0);
    drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd3);
    expect_val(K_A, 32'hDEAD_BEEF, "load_entry3");
    expect_val(K_CNT, 32'd1, "load_cnt");
    drive(1'b0, 3'd0, 32'd0, 3'd3, 3'd3);
    #2;
    rst_n = 1'b0;
    expect_val(K_A, 32'd0, "async_clear_a");
    expect_val(K_B, 32'd0, "async_clear_b");
    expect_val(K_CNT, 32'd0, "async_clear_cnt");
    drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    rst_n = 1'b1;

    // Test 2: write entries 1..7, then sweep both ports.
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 32'h1111_0000 + 32'(i), 3'd0, 3'd0);
      expect_val(K_CNT, 32'(i - 1), "burst_cnt");
    end
    for (int j = 0; j < 8; j++) begin
      drive(1'b0, 3'd0, 32'd0, 3'(j), 3'(7 - j));
      expect_val(K_A, (j == 0) ? 32'd0 : 32'h1111_0000 + 32'(j), "sweep_a");
      expect_val(K_B, (j == 7) ? 32'd0 : 32'h1111_0000 + 32'(7 - j), "sweep_b");
      expect_val(K_CNT, 32'd7, "sweep_cnt");
    end

    // Test 3: write to address 0.
    drive(1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 3'd0);
    expect_val(K_A, ZREG ? 32'd0 : (BYP ? 32'hFFFF_FFFF : 32'd0), "zero_reg_rdw");
    drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd1);
    exp_cnt = ZREG ? 7 : 8;
    expect_val(K_A, ZREG ? 32'd0 : 32'hFFFF_FFFF, "zero_reg_read");
    expect_val(K_B, 32'h1111_0001, "zero_reg_other");
    expect_val(K_CNT, 32'(exp_cnt), "zero_reg_cnt");

    // Test 4: read-during-write on entry 5.
    drive(1'b1, 3'd5, 32'hA5A5_A5A5, 3'd0, 3'd0);
    exp_cnt = exp_cnt + 1;
    drive(1'b1, 3'd5, 32'h5A5A_5A5A, 3'd5, 3'd4);
    expect_val(K_A, BYP ? 32'h5A5A_5A5A : 32'hA5A5_A5A5, "rdw_pre_edge");
    expect_val(K_B, 32'h1111_0004, "rdw_other_port");
    expect_val(K_CNT, 32'(exp_cnt), "rdw_cnt_pre");
    exp_cnt = exp_cnt + 1;
    drive(1'b0, 3'd0, 32'd0, 3'd5, 3'd5);
    expect_val(K_A, 32'h5A5A_5A5A, "rdw_post_edge_a");
    expect_val(K_B, 32'h5A5A_5A5A, "rdw_post_edge_b");
    expect_val(K_CNT, 32'(exp_cnt), "rdw_cnt_post");

    // Test 5: 256 writes to entry 1 from a cleared counter.
    drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd0);
    rst_n = 1'b1;
    expect_val(K_CNT, 32'd0, "wrap_start_cnt");
    for (int k = 0; k < 256; k++) begin
      drive(1'b1, 3'd1, 32'hC000_0000 + 32'(k), 3'd1, 3'd0);
      fwd_v = 32'hC000_0000 + 32'(k);
      old_v = (k == 0) ? 32'd0 : 32'hC000_0000 + 32'(k - 1);
      expect_val(K_A, BYP ? fwd_v : old_v, "wrap_rdw");
      expect_val(K_CNT, 32'(k), "wrap_cnt");
    end
    drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd2);
    expect_val(K_A, 32'hC000_00FF, "wrap_last_data");
    expect_val(K_B, 32'd0, "wrap_other_entry");
    expect_val(K_CNT, 32'd0, "wrap_cnt_zero");

    // Test 6: reset dropped between two back-to-back writes.
    drive(1'b1, 3'd2, 32'h2222_2222, 3'd2, 3'd6);
    expect_val(K_A, BYP ? 32'h2222_2222 : 32'd0, "burst_first_pre");
    drive(1'b1, 3'd6, 32'h6666_6666, 3'd2, 3'd6);
    #2;
    rst_n = 1'b0;
    expect_val(K_A, 32'd0, "burst_reset_a");
    expect_val(K_B, 32'd0, "burst_reset_b");
    expect_val(K_CNT, 32'd0, "burst_reset_cnt");
    drive(1'b1, 3'd6, 32'h8888_8888, 3'd6, 3'd2);
    expect_val(K_A, 32'd0, "in_reset_no_forward");
    expect_val(K_CNT, 32'd0, "in_reset_cnt");
    drive(1'b1, 3'd6, 32'h7777_7777, 3'd6, 3'd2);
    rst_n = 1'b1;
    expect_val(K_A, BYP ? 32'h7777_7777 : 32'd0, "release_pre_edge");
    expect_val(K_B, 32'd0, "release_entry2");
    expect_val(K_CNT, 32'd0, "release_cnt_pre");
    drive(1'b0, 3'd0, 32'd0, 3'd6, 3'd2);
    expect_val(K_A, 32'h7777_7777, "release_write_lands");
    expect_val(K_B, 32'd0, "later_write_lost");
    expect_val(K_CNT, 32'd1, "release_cnt_post");
    drive(1'b0, 3'd0, 32'd0, 3'd1, 3'd5);
    expect_val(K_A, 32'd0, "cleared_entry1");
    expect_val(K_B, 32'd0, "cleared_entry5");

    // Drain the scoreboard.
    drive(1'b0, 3'd0, 32'd0, 3'd0, 3'd0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
